uart_rx_frame_sampler: RTL and testbench
========================================

// Module: uart_rx_frame_sampler
// PURPOSE
// - Synthesizable UART receive front-end that sits directly upstream of the slave monitor BFM.
// - Oversamples the serial line and reassembles each character into a parallel frame.
// - Hands frames out over a valid/ready handshake, with per-frame parity/framing status.
// - The slave monitor BFM pops frames from here instead of bit-sampling the interface itself.
// PARAMETERS
// - DATA_WIDTH  8   data bits per character; legal 5..8; sent LSB first
// - OVERSAMPLE  16  baud_tick pulses per bit period; even, >=4
// - PARITY_EN   1   1 = a parity bit follows the data bits
// - PARITY_ODD  0   0 = even parity, 1 = odd parity; ignored if PARITY_EN=0
// - STOP_BITS   1   number of stop bits; 1 or 2
// PORTS
// - clk          in   1           single clock; all state updates on rising edge
// - rst_n        in   1           asynchronous reset, active-low
// - baud_tick    in   1           1-cycle enable pulse at OVERSAMPLE x baud rate
// - rx           in   1           serial line, idle high; asynchronous to clk
// - frame_ready  in   1           consumer accepts the frame when frame_valid && frame_ready
// - frame_valid  out  1           output buffer holds an unconsumed frame
// - frame_data   out  DATA_WIDTH  received character; bit 0 = first data bit on the line
// - parity_err   out  1           sampled parity mismatched; 0 when PARITY_EN=0
// - framing_err  out  1           at least one stop bit was sampled low
// - overrun_cnt  out  8           frames dropped because the buffer was full; saturates at 255
// - busy         out  1           FSM is not IDLE
// BEHAVIOUR
// - Reset: all outputs 0, FSM = IDLE, synchronizer flops = 1, tick counter and bit counter = 0.
// - rx input: passes through a 2-flop synchronizer (rx_s) before any use.
// - FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
//   - Counters advance only on cycles where baud_tick=1.
// - IDLE:
//   - rx_s=0 on a baud_tick -> START with tick_cnt cleared.
// - START:
//   - Sample rx_s at tick_cnt = OVERSAMPLE/2-1 (mid-bit).
//   - If rx_s=1 -> false start; return to IDLE; no frame is produced.
//   - Otherwise -> DATA.
// - DATA / PARITY / STOP:
//   - Each bit is sampled when tick_cnt reaches OVERSAMPLE-1 after the previous sample point.
//   - tick_cnt then wraps to 0.
//   - DATA collects DATA_WIDTH bits LSB first, then moves to PARITY if PARITY_EN, else STOP.
//   - parity_err_next = XOR(data bits, parity bit) ^ PARITY_ODD.
//   - STOP samples STOP_BITS bits; any low sample sets framing_err_next.
// - End of frame, at the last stop sample:
//   - If the buffer is free, or is being popped in this same cycle, load data and flags.
//   - frame_valid=1 from the next cycle; latency = 1 clk after the baud_tick of the last stop sample.
//   - If the buffer is full and not popped: the new frame is discarded and overrun_cnt increments (saturating).
//   - Next state: IDLE if the last stop sample was 1; WAIT_HIGH if it was 0 (break / line stuck low).
//   - Both destinations apply whether the frame was loaded or dropped.
// - WAIT_HIGH:
//   - Stays until rx_s=1 on a baud_tick, then -> IDLE.
//   - Prevents a held-low line from being read as back-to-back 0x00 frames.
// - Handshake:
//   - frame_data, parity_err and framing_err stay stable while frame_valid=1 && !frame_ready.
//   - frame_valid drops the cycle after a pop unless a new frame loads in that same cycle.
//   - Load and pop in the same cycle -> frame_valid stays 1 with the new contents.
// - Timing:
//   - Reception proceeds independently of frame_ready.
//   - frame_ready is never combinationally dependent on frame_valid.
// - Reset mid-frame: partial frame discarded; returns to IDLE; no frame is emitted.
// - baud_tick held low: FSM and counters freeze; no timeout.
// TESTING
// - Tests run at OVERSAMPLE=16 unless noted; config is 8N1 unless noted; frame_ready=1 unless noted.
// - 1) 8N1, PARITY_EN=0: send 0xA5 -> one frame_valid pulse, frame_data=0xA5, both error flags 0.
// - 2) 8E1: send 0x03 with parity bit=1 (wrong) -> frame_data=0x03, parity_err=1.
//      Resend with parity=0 -> parity_err=0.
// - 3) Framing: send 0x55 with stop bit low, then hold rx low for 3 bit times -> one frame, framing_err=1.
//      No further frame until rx rises and a new start bit arrives.
// - 4) Glitch: rx low for 4 ticks, then high -> busy pulses, returns to IDLE, no frame_valid.
// - 5) Backpressure: frame_ready=0; send 0x11, 0x22, 0x33 -> frame_data holds 0x11, overrun_cnt=2.
//      Raise frame_ready -> 0x11 popped, buffer empty.
// - 6) Reset mid-frame: assert rst_n=0 during data bit 4 of 0xF0 -> outputs 0 immediately.
//      After release, send 0x0F -> frame_data=0x0F only.

Source files
------------

// File: rtl/uart_rx_frame_sampler.sv
// UART receive front-end: oversampled serial line in, one buffered parallel frame out.
// Each frame carries parity and framing status and leaves over a valid/ready handshake.
module uart_rx_frame_sampler #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  rx,
  input  logic                  frame_ready,
  output logic                  frame_valid,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic [7:0]            overrun_cnt,
  output logic                  busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 3;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rx_s;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_acc;
  logic                  perr_acc;
  logic                  fe_acc;
  logic                  sample_pt;
  logic                  pop;
  logic                  can_load;

  // Handshake: a frame transfers on any rising edge where frame_valid && frame_ready;
  // the buffer contents are held while frame_valid is high and frame_ready is low.
  assign sample_pt = baud_tick && (tick_cnt == TICK_LAST);
  assign pop       = frame_valid && frame_ready;
  assign can_load  = !frame_valid || frame_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par_acc     <= 1'b0;
      perr_acc    <= 1'b0;
      fe_acc      <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      // A load later in this block overrides the pop.
      if (pop) frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (baud_tick && !rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (baud_tick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              par_acc  <= 1'b0;
              perr_acc <= 1'b0;
              fe_acc   <= 1'b0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (sample_pt) begin
            tick_cnt <= '0;
            shift    <= {rx_s, shift[DATA_WIDTH-1:1]};
            par_acc  <= par_acc ^ rx_s;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (sample_pt) begin
            tick_cnt <= '0;
            perr_acc <= par_acc ^ rx_s ^ PODD;
            state    <= STOP;
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (sample_pt) begin
            tick_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (can_load) begin
                frame_valid <= 1'b1;
                frame_data  <= shift;
                parity_err  <= perr_acc;
                framing_err <= fe_acc | !rx_s;
              end else if (overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 1'b1;
              end
              // A low final stop bit means a break or stuck line; wait for it to recover.
              state <= rx_s ? IDLE : WAIT_HIGH;
            end else begin
              fe_acc  <= fe_acc | !rx_s;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (baud_tick && rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Bench for uart_rx_frame_sampler: an 8N1 instance and an 8E1 instance driven by serial frames
// built from plain bit lists, with received frames compared against expected values.
module tb_uart_rx_frame_sampler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baud_tick = 1'b0;
  logic tick_en = 1'b1;
  logic rx_n = 1'b1, rx_p = 1'b1;
  logic ready_n = 1'b1, ready_p = 1'b1;

  logic       fv_n, pe_n, fe_n, busy_n;
  logic [7:0] fd_n, ov_n;
  logic       fv_p, pe_p, fe_p, busy_p;
  logic [7:0] fd_p, ov_p;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned tick_count = 0;
  logic [9:0] got_n[$];
  logic [9:0] got_p[$];
  logic busy_seen_n = 1'b0;

  uart_rx_frame_sampler #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_n), .frame_ready(ready_n),
    .frame_valid(fv_n), .frame_data(fd_n), .parity_err(pe_n), .framing_err(fe_n),
    .overrun_cnt(ov_n), .busy(busy_n));

  uart_rx_frame_sampler #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_p), .frame_ready(ready_p),
    .frame_valid(fv_p), .frame_data(fd_p), .parity_err(pe_p), .framing_err(fe_p),
    .overrun_cnt(ov_p), .busy(busy_p));

  // clock / baud tick / reset-independent bookkeeping
  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    baud_tick = tick_en && !baud_tick;
  end

  always @(posedge clk) if (baud_tick) tick_count <= tick_count + 1;

  // Record every frame that actually transfers, as {framing_err, parity_err, data}.
  always @(negedge clk) begin
    if (rst_n && fv_n && ready_n) got_n.push_back({fe_n, pe_n, fd_n});
    if (rst_n && fv_p && ready_p) got_p.push_back({fe_p, pe_p, fd_p});
    if (busy_n) busy_seen_n = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    int unsigned target;
    target = tick_count + n;
    while (tick_count < target) @(negedge clk);
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx_n = v;
  endtask

  task automatic set_ready_n(input logic v);
    @(posedge clk);
    #2 ready_n = v;
  endtask

  // Start bit, 8 data bits LSB first, parity bit (8E1 instance only), one stop bit.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic pbit, input logic stop_val);
    set_rx(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      wait_ticks(16);
    end
    if (sel) begin
      set_rx(sel, pbit);
      wait_ticks(16);
    end
    set_rx(sel, stop_val);
    wait_ticks(16);
  endtask

  function automatic logic even_parity_err(input logic [7:0] d, input logic pbit);
    return (($countones(d) + int'(pbit)) % 2) != 0;
  endfunction

  // scenarios
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({fv_n, fd_n, pe_n, fe_n, ov_n, busy_n} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_n_outputs: got %h expected 0", {fv_n, fd_n, pe_n, fe_n, ov_n, busy_n});
    end
    n_tests++;
    if ({fv_p, fd_p, pe_p, fe_p, ov_p, busy_p} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_p_outputs: got %h expected 0", {fv_p, fd_p, pe_p, fe_p, ov_p, busy_p});
    end
    rst_n = 1'b1;
    wait_ticks(4);
    n_tests++;
    if ({fv_n, busy_n, fv_p, busy_p} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected 0000", {fv_n, busy_n, fv_p, busy_p});
    end
  endtask

  task automatic test_basic_8n1;
    logic [9:0] g;
    got_n.delete();
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    wait_ticks(4);
    n_tests++;
    if (got_n.size() !== 1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d frames expected 1", got_n.size());
    end
    g = (got_n.size() > 0) ? got_n[0] : 'x;
    n_tests++;
    if (g !== {2'b00, 8'hA5}) begin
      n_fail++;
      $display("FAIL basic_frame: got %h expected %h", g, {2'b00, 8'hA5});
    end
  endtask

  task automatic test_random_8n1;
    logic [9:0] exp_q[$];
    logic [7:0] d;
    logic [9:0] g;
    got_n.delete();
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back({2'b00, d});
      send_frame(1'b0, d, 1'b0, 1'b1);
    end
    wait_ticks(4);
    n_tests++;
    if (got_n.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d frames expected %0d", got_n.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_n.size()) ? got_n[i] : 'x;
      n_tests++;
      if (g !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_frame[%0d]: got %h expected %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_parity;
    logic [9:0] exp_q[$];
    logic [7:0] d;
    logic       pb;
    logic [9:0] g;
    got_p.delete();
    send_frame(1'b1, 8'h03, 1'b1, 1'b1);
    exp_q.push_back({1'b0, 1'b1, 8'h03});
    send_frame(1'b1, 8'h03, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 8'h03});
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, even_parity_err(d, pb), d});
      send_frame(1'b1, d, pb, 1'b1);
    end
    wait_ticks(4);
    n_tests++;
    if (got_p.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL parity_count: got %0d frames expected %0d", got_p.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_p.size()) ? got_p[i] : 'x;
      n_tests++;
      if (g !== exp_q[i]) begin
        n_fail++;
        $display("FAIL parity_frame[%0d]: got %h expected %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_framing;
    logic [9:0] g;
    got_n.delete();
    send_frame(1'b0, 8'h55, 1'b0, 1'b0);
    wait_ticks(48);
    n_tests++;
    if (got_n.size() !== 1) begin
      n_fail++;
      $display("FAIL framing_count_while_low: got %0d frames expected 1", got_n.size());
    end
    g = (got_n.size() > 0) ? got_n[0] : 'x;
    n_tests++;
    if (g !== {1'b1, 1'b0, 8'h55}) begin
      n_fail++;
      $display("FAIL framing_frame: got %h expected %h", g, {1'b1, 1'b0, 8'h55});
    end
    n_tests++;
    if (busy_n !== 1'b1) begin
      n_fail++;
      $display("FAIL framing_busy_while_low: got %b expected 1", busy_n);
    end
    rx_n = 1'b1;
    wait_ticks(4);
    n_tests++;
    if (busy_n !== 1'b0) begin
      n_fail++;
      $display("FAIL framing_idle_after_high: got %b expected 0", busy_n);
    end
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
    wait_ticks(4);
    g = (got_n.size() > 1) ? got_n[1] : 'x;
    n_tests++;
    if (got_n.size() !== 2 || g !== {2'b00, 8'h3C}) begin
      n_fail++;
      $display("FAIL framing_recover: got %0d frames last %h expected 2 frames last %h", got_n.size(), g, {2'b00, 8'h3C});
    end
  endtask

  task automatic test_glitch;
    got_n.delete();
    busy_seen_n = 1'b0;
    rx_n = 1'b0;
    wait_ticks(4);
    rx_n = 1'b1;
    wait_ticks(16);
    n_tests++;
    if (busy_seen_n !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_pulse: got %b expected 1", busy_seen_n);
    end
    n_tests++;
    if (busy_n !== 1'b0 || got_n.size() !== 0) begin
      n_fail++;
      $display("FAIL glitch_no_frame: busy %b frames %0d expected busy 0 frames 0", busy_n, got_n.size());
    end
  endtask

  task automatic test_backpressure;
    logic [9:0] g;
    got_n.delete();
    set_ready_n(1'b0);
    send_frame(1'b0, 8'h11, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1);
    send_frame(1'b0, 8'h33, 1'b0, 1'b1);
    wait_ticks(4);
    n_tests++;
    if ({fv_n, fd_n, pe_n, fe_n} !== {1'b1, 8'h11, 2'b00}) begin
      n_fail++;
      $display("FAIL bp_hold: got valid %b data %h flags %b%b expected valid 1 data 11 flags 00", fv_n, fd_n, pe_n, fe_n);
    end
    n_tests++;
    if (ov_n !== 8'd2) begin
      n_fail++;
      $display("FAIL bp_overrun: got %0d expected 2", ov_n);
    end
    set_ready_n(1'b1);
    repeat (3) @(negedge clk);
    g = (got_n.size() > 0) ? got_n[0] : 'x;
    n_tests++;
    if (got_n.size() !== 1 || g !== {2'b00, 8'h11} || fv_n !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_pop: got %0d frames first %h valid %b expected 1 frame 011 valid 0", got_n.size(), g, fv_n);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_q[$];
    logic [7:0] d;
    logic [9:0] g;
    logic [7:0] ov_before;
    bit done;
    done = 1'b0;
    ov_before = ov_n;
    got_n.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          d = 8'($urandom_range(0, 255));
          exp_q.push_back({2'b00, d});
          send_frame(1'b0, d, 1'b0, 1'b1);
        end
        wait_ticks(4);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2 ready_n = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 20)) @(posedge clk);
        end
      end
    join
    set_ready_n(1'b1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (got_n.size() !== exp_q.size() || ov_n !== ov_before) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d frames overrun %0d expected %0d frames overrun %0d", got_n.size(), ov_n, exp_q.size(), ov_before);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_n.size()) ? got_n[i] : 'x;
      n_tests++;
      if (g !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_frame[%0d]: got %h expected %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_tick_freeze;
    logic [7:0] d;
    logic [9:0] g;
    d = 8'($urandom_range(0, 255));
    got_p.delete();
    fork
      send_frame(1'b1, d, 1'b0, 1'b1);
      begin
        wait_ticks(60);
        tick_en = 1'b0;
        repeat (100) @(negedge clk);
        n_tests++;
        if (busy_p !== 1'b1 || got_p.size() !== 0) begin
          n_fail++;
          $display("FAIL freeze_hold: busy %b frames %0d expected busy 1 frames 0", busy_p, got_p.size());
        end
        tick_en = 1'b1;
      end
    join
    wait_ticks(4);
    g = (got_p.size() > 0) ? got_p[0] : 'x;
    n_tests++;
    if (got_p.size() !== 1 || g !== {1'b0, even_parity_err(d, 1'b0), d}) begin
      n_fail++;
      $display("FAIL freeze_frame: got %0d frames first %h expected 1 frame %h", got_p.size(), g, {1'b0, even_parity_err(d, 1'b0), d});
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] g;
    got_n.delete();
    fork
      send_frame(1'b0, 8'hF0, 1'b0, 1'b1);
      begin
        wait_ticks(16 + 4 * 16 + 8);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({fv_n, fd_n, pe_n, fe_n, ov_n, busy_n} !== 20'h0) begin
          n_fail++;
          $display("FAIL midreset_outputs: got %h expected 0", {fv_n, fd_n, pe_n, fe_n, ov_n, busy_n});
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    wait_ticks(8);
    send_frame(1'b0, 8'h0F, 1'b0, 1'b1);
    wait_ticks(4);
    g = (got_n.size() > 0) ? got_n[0] : 'x;
    n_tests++;
    if (got_n.size() !== 1 || g !== {2'b00, 8'h0F}) begin
      n_fail++;
      $display("FAIL midreset_next_frame: got %0d frames first %h expected 1 frame 00f", got_n.size(), g);
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_random_8n1();
    test_parity();
    test_framing();
    test_glitch();
    test_backpressure();
    test_back_to_back();
    test_tick_freeze();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
